// File: rtl/gb_cpu_mem_bridge.sv
// gb_cpu_mem_bridge: turns GameBoy CPU bus strobes into single req/ack memory
// transactions, stalling the CPU via WAIT_n/CLKEN until the memory side completes.
module gb_cpu_mem_bridge #(
    parameter int CEN_DIV = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        CLK_n,
    input  logic        RESET_n,
    output logic        CLKEN,
    output logic        WAIT_n,
    input  logic        MREQ_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic [15:0] A,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err
);
    localparam int CW = $clog2(CEN_DIV);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_tmo, r_di, r_wdata;
    logic [15:0]   r_addr;
    logic          r_rd_prev, r_wr_prev, r_wait_n, r_req, r_we, r_err;
    logic          w_rd_start, w_wr_start, w_start, w_last;

    assign w_rd_start  = r_rd_prev & ~RD_n & ~MREQ_n;
    assign w_wr_start  = r_wr_prev & ~WR_n & ~MREQ_n;
    assign w_start     = w_rd_start | w_wr_start;
    assign w_last      = r_cnt == CW'(CEN_DIV - 1);
    // The divider freezes from the detect cycle onward, so the pending T-state edge survives the stall
    assign CLKEN       = w_last && r_state == IDLE && !w_start;
    assign WAIT_n      = r_wait_n;
    assign DI          = r_di;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign timeout_err = r_err;

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_tmo     <= 8'd0;
            r_di      <= 8'hFF;
            r_wdata   <= 8'd0;
            r_addr    <= 16'd0;
            r_rd_prev <= 1'b1;
            r_wr_prev <= 1'b1;
            r_wait_n  <= 1'b1;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rd_prev <= RD_n;
            r_wr_prev <= WR_n;
            if (r_state == IDLE && !w_start)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            case (r_state)
                IDLE: if (w_start) begin
                    r_addr   <= A;
                    if (w_wr_start)
                        r_wdata <= DO;
                    r_we     <= w_wr_start;
                    r_req    <= 1'b1;
                    r_wait_n <= 1'b0;
                    r_tmo    <= 8'd0;
                    r_state  <= REQ;
                end
                REQ: if (mem_ack) begin
                    r_req   <= 1'b0;
                    if (!r_we)
                        r_di <= mem_rdata;
                    r_state <= DONE;
                end else if (r_tmo == 8'(TIMEOUT - 1)) begin
                    r_req   <= 1'b0;
                    if (!r_we)
                        r_di <= 8'hFF;
                    r_err   <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_tmo <= r_tmo + 8'd1;
                end
                default: begin
                    r_wait_n <= 1'b1;
                    r_we     <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gb_cpu_mem_bridge.sv
// tb_gb_cpu_mem_bridge: scenario tasks with a request/read-data scoreboard for the CPU-to-memory bridge.
module tb_gb_cpu_mem_bridge;
    typedef struct packed {logic we; logic [15:0] addr; logic [7:0] wdata;} req_t;

    logic        CLK_n = 0, RESET_n = 0, MREQ_n = 1, RD_n = 1, WR_n = 1, mem_ack = 0;
    logic [15:0] A = 16'd0;
    logic [7:0]  DO = 8'd0, mem_rdata = 8'd0;
    logic        CLKEN, WAIT_n, mem_req, mem_we, timeout_err;
    logic [7:0]  DI, mem_wdata;
    logic [15:0] mem_addr;
    int          checks = 0, errors = 0, n_clken = 0, n_wait = 0, n_req = 0;
    req_t        exp_q[$];
    logic [7:0]  di_q[$];
    req_t        e;
    logic [7:0]  d;

    gb_cpu_mem_bridge #(.CEN_DIV(4), .TIMEOUT(8)) dut (
        .CLK_n(CLK_n), .RESET_n(RESET_n), .CLKEN(CLKEN), .WAIT_n(WAIT_n),
        .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n), .A(A), .DO(DO), .DI(DI),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 CLK_n = ~CLK_n;

    always @(posedge CLK_n) begin
        if (CLKEN) n_clken <= n_clken + 1;
        if (!WAIT_n) n_wait <= n_wait + 1;
        if (mem_req) n_req <= n_req + 1;
    end

    task automatic step();
        @(posedge CLK_n);
        #2;
    endtask

    task automatic test_reset();
        step();
        step();
        checks += 8;
        if (CLKEN !== 1'b0) begin errors++; $display("FAIL reset_clken: got %b exp 0", CLKEN); end
        if (WAIT_n !== 1'b1) begin errors++; $display("FAIL reset_wait: got %b exp 1", WAIT_n); end
        if (DI !== 8'hFF) begin errors++; $display("FAIL reset_di: got %h exp ff", DI); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem_req); end
        if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", mem_we); end
        if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0000", mem_addr); end
        if (mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 00", mem_wdata); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b exp 0", timeout_err); end
        RESET_n = 1;
    endtask

    task automatic test_freerun();
        int bw = n_wait, br = n_req;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (CLKEN !== ((i % 4) == 2)) begin
                errors++; $display("FAIL freerun_clken[%0d]: got %b exp %b", i, CLKEN, (i % 4) == 2);
            end
        end
        checks += 2;
        if (n_wait - bw !== 0) begin errors++; $display("FAIL freerun_wait: got %0d exp 0", n_wait - bw); end
        if (n_req - br !== 0) begin errors++; $display("FAIL freerun_req: got %0d exp 0", n_req - br); end
    endtask

    task automatic test_write();
        int bw, bc, br;
        A = 16'hC000; DO = 8'hA5; MREQ_n = 0; WR_n = 0;
        exp_q.push_back('{1'b1, 16'hC000, 8'hA5});
        bw = n_wait; bc = n_clken; br = n_req;
        step();
        e = exp_q.pop_front();
        checks += 3;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL wr_req_rise: got %b exp 1", mem_req); end
        if ({mem_we, mem_addr, mem_wdata} !== e) begin
            errors++; $display("FAIL wr_request: got %h exp %h", {mem_we, mem_addr, mem_wdata}, e);
        end
        if (WAIT_n !== 1'b0) begin errors++; $display("FAIL wr_wait_low: got %b exp 0", WAIT_n); end
        mem_ack = 1; mem_rdata = 8'h5A;
        step();
        mem_ack = 0;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop: got %b exp 0", mem_req); end
        step();
        checks += 4;
        if (WAIT_n !== 1'b1) begin errors++; $display("FAIL wr_wait_high: got %b exp 1", WAIT_n); end
        if (n_wait - bw !== 2) begin errors++; $display("FAIL wr_wait_len: got %0d exp 2", n_wait - bw); end
        if (DI !== 8'hFF) begin errors++; $display("FAIL wr_di: got %h exp ff", DI); end
        if (n_clken - bc !== 0) begin errors++; $display("FAIL wr_clken_stall: got %0d exp 0", n_clken - bc); end
        repeat (3) step();
        checks++;
        if (n_req - br !== 1) begin errors++; $display("FAIL wr_no_retrigger: got %0d exp 1", n_req - br); end
        WR_n = 1; MREQ_n = 1;
        step();
    endtask

    task automatic test_read();
        int bw, bc;
        A = 16'h0100; MREQ_n = 0; RD_n = 0;
        exp_q.push_back('{1'b0, 16'h0100, 8'hA5});
        bw = n_wait; bc = n_clken;
        step();
        e = exp_q.pop_front();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_req_rise: got %b exp 1", mem_req); end
        if ({mem_we, mem_addr, mem_wdata} !== e) begin
            errors++; $display("FAIL rd_request: got %h exp %h", {mem_we, mem_addr, mem_wdata}, e);
        end
        repeat (4) step();
        mem_ack = 1; mem_rdata = 8'h3E;
        di_q.push_back(8'h3E);
        step();
        mem_ack = 0;
        d = di_q.pop_front();
        checks += 2;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b exp 0", mem_req); end
        if (DI !== d) begin errors++; $display("FAIL rd_di: got %h exp %h", DI, d); end
        step();
        checks += 3;
        if (WAIT_n !== 1'b1) begin errors++; $display("FAIL rd_wait_high: got %b exp 1", WAIT_n); end
        if (n_wait - bw !== 6) begin errors++; $display("FAIL rd_wait_len: got %0d exp 6", n_wait - bw); end
        if (n_clken - bc !== 0) begin errors++; $display("FAIL rd_clken_stall: got %0d exp 0", n_clken - bc); end
        RD_n = 1; MREQ_n = 1;
        bc = n_clken;
        repeat (4) step();
        checks += 2;
        if (n_clken - bc !== 1) begin errors++; $display("FAIL rd_clken_resume: got %0d exp 1", n_clken - bc); end
        if (DI !== 8'h3E) begin errors++; $display("FAIL rd_di_hold: got %h exp 3e", DI); end
    endtask

    task automatic test_both_strobes();
        int br;
        A = 16'h1234; DO = 8'h11; MREQ_n = 0; RD_n = 0; WR_n = 0;
        exp_q.push_back('{1'b1, 16'h1234, 8'h11});
        br = n_req;
        step();
        e = exp_q.pop_front();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL both_req_rise: got %b exp 1", mem_req); end
        if ({mem_we, mem_addr, mem_wdata} !== e) begin
            errors++; $display("FAIL both_request: got %h exp %h", {mem_we, mem_addr, mem_wdata}, e);
        end
        mem_ack = 1; mem_rdata = 8'h77;
        step();
        mem_ack = 0;
        repeat (4) step();
        checks += 2;
        if (n_req - br !== 1) begin errors++; $display("FAIL both_single: got %0d exp 1", n_req - br); end
        if (DI !== 8'h3E) begin errors++; $display("FAIL both_di: got %h exp 3e", DI); end
        RD_n = 1; WR_n = 1; MREQ_n = 1;
        step();
    endtask

    task automatic test_reset_mid();
        A = 16'h3000; MREQ_n = 0; RD_n = 0;
        exp_q.push_back('{1'b0, 16'h3000, 8'h11});
        step();
        e = exp_q.pop_front();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_req_rise: got %b exp 1", mem_req); end
        if ({mem_we, mem_addr, mem_wdata} !== e) begin
            errors++; $display("FAIL rst_request: got %h exp %h", {mem_we, mem_addr, mem_wdata}, e);
        end
        RESET_n = 0;
        #1;
        checks += 3;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_async_req: got %b exp 0", mem_req); end
        if (WAIT_n !== 1'b1) begin errors++; $display("FAIL rst_async_wait: got %b exp 1", WAIT_n); end
        if (DI !== 8'hFF) begin errors++; $display("FAIL rst_async_di: got %h exp ff", DI); end
        mem_ack = 1; mem_rdata = 8'h99; RD_n = 1; MREQ_n = 1;
        step();
        RESET_n = 1;
        step();
        mem_ack = 0;
        checks += 3;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_late_req: got %b exp 0", mem_req); end
        if (WAIT_n !== 1'b1) begin errors++; $display("FAIL rst_late_wait: got %b exp 1", WAIT_n); end
        if (DI !== 8'hFF) begin errors++; $display("FAIL rst_late_di: got %h exp ff", DI); end
        A = 16'h4000; MREQ_n = 0; RD_n = 0;
        exp_q.push_back('{1'b0, 16'h4000, 8'h00});
        step();
        e = exp_q.pop_front();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_next_req: got %b exp 1", mem_req); end
        if ({mem_we, mem_addr, mem_wdata} !== e) begin
            errors++; $display("FAIL rst_next_request: got %h exp %h", {mem_we, mem_addr, mem_wdata}, e);
        end
        mem_ack = 1; mem_rdata = 8'hC3;
        di_q.push_back(8'hC3);
        step();
        mem_ack = 0;
        d = di_q.pop_front();
        checks++;
        if (DI !== d) begin errors++; $display("FAIL rst_next_di: got %h exp %h", DI, d); end
        step();
        checks++;
        if (WAIT_n !== 1'b1) begin errors++; $display("FAIL rst_next_wait: got %b exp 1", WAIT_n); end
        RD_n = 1; MREQ_n = 1;
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        A = 16'h2000; MREQ_n = 0; RD_n = 0;
        exp_q.push_back('{1'b0, 16'h2000, 8'h00});
        step();
        e = exp_q.pop_front();
        checks += 2;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req_rise: got %b exp 1", mem_req); end
        if ({mem_we, mem_addr, mem_wdata} !== e) begin
            errors++; $display("FAIL to_request: got %h exp %h", {mem_we, mem_addr, mem_wdata}, e);
        end
        while (mem_req === 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks += 3;
        if (n !== 8) begin errors++; $display("FAIL to_req_cycles: got %0d exp 8", n); end
        if (DI !== 8'hFF) begin errors++; $display("FAIL to_di: got %h exp ff", DI); end
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b exp 1", timeout_err); end
        step();
        RD_n = 1; MREQ_n = 1;
        mem_ack = 1; mem_rdata = 8'h55;
        step();
        mem_ack = 0;
        step();
        checks += 4;
        if (DI !== 8'hFF) begin errors++; $display("FAIL to_stray_di: got %h exp ff", DI); end
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b exp 1", timeout_err); end
        if (mem_req !== 1'b0) begin errors++; $display("FAIL to_stray_req: got %b exp 0", mem_req); end
        if (WAIT_n !== 1'b1) begin errors++; $display("FAIL to_stray_wait: got %b exp 1", WAIT_n); end
    endtask

    initial begin
        test_reset();
        test_freerun();
        test_write();
        test_read();
        test_both_strobes();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/gb_cpu_mem_bridge.md
Name: gb_cpu_mem_bridge

Overview:
- Downstream consumer of the GameBoy CPU bus strobes (MREQ_n/RD_n/WR_n/A/DO). Produces the CPU's CLKEN, WAIT_n and DI.
- Converts each CPU memory access into a single req/ack transaction toward the SDRAM/ROM arbiter.
- Stretches the CPU, by holding WAIT_n low and suppressing CLKEN, until the memory side completes.
- Returns read data on DI, and keeps it stable until the CPU latches it in T3.

Parameters:
- CEN_DIV, 4: CLK_n cycles per CPU T-state. Legal range 2..16.
- TIMEOUT, 64: maximum CLK_n cycles spent in REQ before the access is aborted. Legal range 1..255.

Ports:
- CLK_n  in  1  system clock; all state updates on posedge.
- RESET_n  in  1  asynchronous, active-low reset.
- CLKEN  out  1  CPU clock enable, one-cycle pulse per T-state.
- WAIT_n  out  1  CPU wait request, active-low, registered.
- MREQ_n  in  1  CPU memory request strobe, changes on negedge.
- RD_n  in  1  CPU read strobe.
- WR_n  in  1  CPU write strobe.
- A  in  16  CPU address.
- DO  in  8  CPU write data.
- DI  out  8  CPU read data, registered.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  1 = write access, valid while mem_req=1.
- mem_addr  out  16  captured address.
- mem_wdata  out  8  captured write data.
- mem_ack  in  1  one-cycle completion pulse from the memory side.
- mem_rdata  in  8  read data, valid in the same cycle as mem_ack.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (async, RESET_n=0):
  - Outputs: CLKEN=0, WAIT_n=1, DI=8'hFF, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout_err=0.
  - Internal: divider cnt=0, state=IDLE, rd_prev=1, wr_prev=1, timeout counter=0.
  - Reset mid-transaction drops mem_req immediately and discards the access. A late mem_ack after reset is ignored.
- Divider:
  - cnt counts 0..CEN_DIV-1 and wraps.
  - cnt advances only when state==IDLE and start==0; otherwise it holds.
  - CLKEN = (cnt==CEN_DIV-1) && state==IDLE && !start. This is combinational from registers and the start detect. No glitches are permitted: every term is registered or a registered-edge compare.
- Strobe detect:
  - rd_prev and wr_prev register RD_n and WR_n each posedge.
  - rd_start = rd_prev & ~RD_n & ~MREQ_n.
  - wr_start = wr_prev & ~WR_n & ~MREQ_n.
  - start = rd_start | wr_start.
  - IORQ accesses are not handled (no IORQ_n input).
  - If rd_start and wr_start occur in the same cycle, the write wins.
- FSM:
  - IDLE:
    - On start at posedge k: capture A to mem_addr; DO to mem_wdata (writes only; unchanged on reads); mem_we=wr_start; mem_req=1; WAIT_n=0; timeout counter=0. Go to REQ.
    - All these take effect at k+1.
  - REQ:
    - mem_req and WAIT_n are held.
    - On mem_ack: mem_req=0. For a read, DI=mem_rdata; for a write, DI is unchanged. Go to DONE.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without ack: mem_req=0, DI=8'hFF for reads, timeout_err=1. Go to DONE.
    - An ack arriving in the first REQ cycle (zero-wait memory) is legal.
  - DONE:
    - WAIT_n=1 and mem_we=0 for one cycle, then go to IDLE.
    - The divider resumes at its held cnt, so the pending CLKEN fires at the first IDLE cycle where cnt==CEN_DIV-1.
- Timing guarantees:
  - Detect latency: edge visible at posedge k; mem_req and WAIT_n=0 at k+1.
  - No CLKEN pulse is emitted between the start detect and DONE.
  - Minimum stretch is 3 cycles (detect, REQ with immediate ack, DONE).
  - DI is stable from the cycle after ack until the next read ack. Writes never modify DI.
  - A strobe still held low after DONE does not retrigger; a new access requires a fresh high-to-low edge.
- Other rules:
  - mem_ack seen in IDLE or DONE is ignored.
  - timeout_err clears only on reset.
  - The timeout counter is 8 bits and never wraps within an access.

Test Plan:
- Free-run, CEN_DIV=4, no strobes: CLKEN pulses every 4th cycle; WAIT_n=1, mem_req=0 throughout.
- Read A=16'h0100, mem_ack 5 cycles after mem_req with rdata=8'h3E:
  - mem_req=1, mem_we=0, mem_addr=16'h0100 one cycle after the RD_n fall.
  - WAIT_n=0 for 6 cycles; no CLKEN while stalled.
  - DI=8'h3E the cycle after ack; CLKEN resumes.
- Write A=16'hC000, DO=8'hA5, ack in the first REQ cycle: mem_we=1, mem_wdata=8'hA5; WAIT_n low exactly 2 cycles; DI unchanged (8'hFF after reset).
- Read with no ack, TIMEOUT=8: mem_req drops after 8 REQ cycles; DI=8'hFF; timeout_err=1 and stays 1; a later stray mem_ack is ignored.
- RD_n and WR_n fall together with MREQ_n=0 and DO=8'h11: a single write transaction (mem_we=1, mem_wdata=8'h11); no read is issued.
- RESET_n pulsed low while in REQ: mem_req=0 and WAIT_n=1 asynchronously; DI=8'hFF; ack arriving during or after reset is ignored; the next read completes normally.
